// File: rtl/pipe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_buf
// Brief    : Elastic inter-stage pipeline register with valid/ready handshake,
//            stall, flush and an optional two-entry skid buffer. Control bits
//            are forced to zero whenever the stage presents a bubble.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_buf #(
  parameter int DATA_W = 102,
  parameter int CTRL_W = 4,
  parameter int SKID   = 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  // upstream side
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  // pipeline control
  input  logic              flush_i,
  // downstream side
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [1:0]        count_o
);

  // --------------------------------------------------------------------------
  // Head register M: always the entry presented downstream.
  // --------------------------------------------------------------------------
  logic              r_m_valid;
  logic [DATA_W-1:0] r_m_data;
  logic [CTRL_W-1:0] r_m_ctrl;

  // Next-state of M, produced by whichever storage variant is built.
  logic              w_m_valid_nxt;
  logic              w_m_load;
  logic [DATA_W-1:0] w_m_data_nxt;
  logic [CTRL_W-1:0] w_m_ctrl_nxt;

  // Handshake terms shared by both variants.
  logic              w_ready;
  logic              w_s_valid;
  logic              w_in_xfer;
  logic              w_out_xfer;

  assign w_in_xfer  = valid_i & w_ready;
  assign w_out_xfer = r_m_valid & ready_i;

  generate
    if (SKID != 0) begin : g_skid
      // ------------------------------------------------------------------------
      // Two-entry variant: skid register S absorbs the one entry that can
      // arrive in the cycle after downstream stalls, so ready_o can be a
      // plain flop with no combinational path back from ready_i.
      // ------------------------------------------------------------------------
      logic              r_s_valid;
      logic [DATA_W-1:0] r_s_data;
      logic [CTRL_W-1:0] r_s_ctrl;
      logic              r_ready;

      logic              w_s_valid_nxt;
      logic              w_s_load;

      // Decide where M and S are refilled from on the coming edge.
      always_comb begin
        w_m_valid_nxt = r_m_valid;
        w_m_load      = 1'b0;
        w_m_data_nxt  = data_i;
        w_m_ctrl_nxt  = ctrl_i;
        w_s_valid_nxt = r_s_valid;
        w_s_load      = 1'b0;
        if (flush_i) begin
          // Flush wins over everything: both slots become bubbles and any
          // concurrent input transfer is dropped.
          w_m_valid_nxt = 1'b0;
          w_s_valid_nxt = 1'b0;
        end else if (!r_m_valid || w_out_xfer) begin
          // M is free (or being vacated this cycle): oldest entry moves in.
          if (r_s_valid) begin
            w_m_load      = 1'b1;
            w_m_valid_nxt = 1'b1;
            w_m_data_nxt  = r_s_data;
            w_m_ctrl_nxt  = r_s_ctrl;
            w_s_valid_nxt = 1'b0;
            if (w_in_xfer) begin
              w_s_load      = 1'b1;
              w_s_valid_nxt = 1'b1;
            end
          end else if (w_in_xfer) begin
            w_m_load      = 1'b1;
            w_m_valid_nxt = 1'b1;
          end else begin
            w_m_valid_nxt = 1'b0;
          end
        end else if (w_in_xfer) begin
          // M stalled and still occupied: park the new entry in S.
          w_s_load      = 1'b1;
          w_s_valid_nxt = 1'b1;
        end
      end

      // Skid slot storage plus the registered ready, which mirrors the
      // emptiness S will have after this edge.
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          r_s_valid <= 1'b0;
          r_s_data  <= '0;
          r_s_ctrl  <= '0;
          r_ready   <= 1'b0;
        end else begin
          r_s_valid <= w_s_valid_nxt;
          r_ready   <= ~w_s_valid_nxt;
          if (w_s_load) begin
            r_s_data <= data_i;
            r_s_ctrl <= ctrl_i;
          end
        end
      end

      assign w_ready   = r_ready;
      assign w_s_valid = r_s_valid;
    end else begin : g_noskid
      // ------------------------------------------------------------------------
      // Single-register variant: ready is combinational so a full M can be
      // replaced in the same edge it drains.
      // ------------------------------------------------------------------------
      assign w_ready       = ~r_m_valid | ready_i;
      assign w_s_valid     = 1'b0;
      assign w_m_load      = w_in_xfer & ~flush_i;
      assign w_m_data_nxt  = data_i;
      assign w_m_ctrl_nxt  = ctrl_i;
      assign w_m_valid_nxt = flush_i    ? 1'b0 :
                             w_in_xfer  ? 1'b1 :
                             w_out_xfer ? 1'b0 :
                                          r_m_valid;
    end
  endgenerate

  // Head register: valid always follows next-state; payload only on a load so
  // data_o keeps its last value through bubbles and flushes.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_ctrl  <= '0;
    end else begin
      r_m_valid <= w_m_valid_nxt;
      if (w_m_load) begin
        r_m_data <= w_m_data_nxt;
        r_m_ctrl <= w_m_ctrl_nxt;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. Control is gated by valid so a bubble can never carry a live
  // RegWrite/MemWrite into the next stage.
  // --------------------------------------------------------------------------
  assign ready_o = w_ready;
  assign valid_o = r_m_valid;
  assign data_o  = r_m_data;
  assign ctrl_o  = r_m_valid ? r_m_ctrl : '0;
  assign count_o = {1'b0, r_m_valid} + {1'b0, w_s_valid};

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_buf
// Brief    : Scoreboard bench for pipe_stage_buf (SKID=1 main instance, plus a
//            SKID=0 instance exercised directly).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_buf;

  localparam int DW = 102;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;

  // SKID=1 instance signals
  logic          valid_i, ready_i, flush_i;
  logic [DW-1:0] data_i;
  logic [CW-1:0] ctrl_i;
  logic          ready_o, valid_o;
  logic [DW-1:0] data_o;
  logic [CW-1:0] ctrl_o;
  logic [1:0]    count_o;

  // SKID=0 instance signals
  logic          v0_i, r0_i, f0_i;
  logic [DW-1:0] d0_i;
  logic [CW-1:0] c0_i;
  logic          r0_o, v0_o;
  logic [DW-1:0] d0_o;
  logic [CW-1:0] c0_o;
  logic [1:0]    n0_o;

  int n_chk  = 0;
  int n_fail = 0;

  // Expected outputs of the SKID=1 instance, {ctrl, data}, oldest first.
  logic [CW+DW-1:0] sb[$];

  pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i), .ctrl_i(ctrl_i),
    .flush_i(flush_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .ctrl_o(ctrl_o),
    .count_o(count_o)
  );

  pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n),
    .valid_i(v0_i), .ready_o(r0_o), .data_i(d0_i), .ctrl_i(c0_i),
    .flush_i(f0_i),
    .valid_o(v0_o), .ready_i(r0_i), .data_o(d0_o), .ctrl_o(c0_o),
    .count_o(n0_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One cycle of stimulus on the SKID=1 instance. er = hand-computed ready_o
  // for this cycle; an entry is expected downstream only if accepted.
  task automatic cyc(input bit vi, input logic [DW-1:0] di, input logic [CW-1:0] ci,
                     input bit ri, input bit fi, input bit er);
    valid_i = vi; data_i = di; ctrl_i = ci; ready_i = ri; flush_i = fi;
    @(negedge clk);
    chk("ready_o", ready_o, er);
    if (fi) sb.delete();
    else if (vi && er) sb.push_back({ci, di});
    @(posedge clk); #1;
  endtask

  // Monitor: compare every downstream transfer against the scoreboard, and
  // require zero control on every bubble.
  always @(negedge clk) begin
    if (rst_n && !valid_o)
      chk("bubble_ctrl", ctrl_o, 0);
    if (rst_n && valid_o && ready_i && !flush_i) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", {ctrl_o, data_o}, 0);
      end else begin
        chk("out_entry", {ctrl_o, data_o}, sb.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    valid_i = 0; ready_i = 0; flush_i = 0; data_i = '0; ctrl_i = '0;
    v0_i = 0; r0_i = 0; f0_i = 0; d0_i = '0; c0_i = '0;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", valid_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_ctrl", ctrl_o, 0);
    chk("rst_data", data_o, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", ready_o, 1);

    // ---- streaming 0x10..0x17, one per cycle, 1-cycle latency ----
    for (int i = 0; i < 8; i++) begin
      cyc(1, DW'(8'h10 + i), 4'b1011, 1, 0, 1);
      chk("stream_valid", valid_o, 1);
      chk("stream_data", data_o, 8'h10 + i);
      chk("stream_count", count_o, 1);
    end
    cyc(0, '0, '0, 1, 0, 1);
    chk("drain_count", count_o, 0);

    // ---- backpressure: A, B fill; C refused ----
    cyc(1, DW'(8'h21), 4'b0110, 0, 0, 1);
    chk("bp_cntA", count_o, 1);
    cyc(1, DW'(8'h22), 4'b0111, 0, 0, 1);
    chk("bp_cntB", count_o, 2);
    chk("bp_rdyB", ready_o, 0);
    cyc(1, DW'(8'h23), 4'b1000, 0, 0, 0);
    chk("bp_cntC", count_o, 2);
    chk("bp_holdA", data_o, 8'h21);
    cyc(0, '0, '0, 1, 0, 0);
    chk("bp_headB", data_o, 8'h22);
    chk("bp_cnt1", count_o, 1);
    chk("bp_rdy_back", ready_o, 1);
    cyc(1, DW'(8'h23), 4'b1000, 1, 0, 1);
    chk("bp_swap_cnt", count_o, 1);
    chk("bp_headC", data_o, 8'h23);
    cyc(0, '0, '0, 1, 0, 1);
    chk("bp_empty", count_o, 0);

    // ---- flush at count 2 with a pending input, then at count 0 ----
    cyc(1, DW'(8'h31), 4'b1001, 0, 0, 1);
    cyc(1, DW'(8'h32), 4'b1001, 0, 0, 1);
    chk("fl_cnt2", count_o, 2);
    cyc(1, DW'(8'h33), 4'b1111, 0, 1, 0);
    chk("fl_valid", valid_o, 0);
    chk("fl_ctrl", ctrl_o, 0);
    chk("fl_count", count_o, 0);
    chk("fl_ready", ready_o, 1);
    cyc(1, DW'(8'h34), 4'b1111, 0, 1, 1);
    chk("fl_discard_valid", valid_o, 0);
    chk("fl_discard_count", count_o, 0);
    cyc(0, '0, '0, 1, 0, 1);
    cyc(0, '0, '0, 1, 0, 1);
    chk("fl_no_ghost", valid_o, 0);

    // ---- bubble control ----
    for (int i = 0; i < 3; i++) begin
      cyc(0, DW'(8'hAA), 4'b1111, 1, 0, 1);
      chk("bub_ctrl", ctrl_o, 0);
      chk("bub_valid", valid_o, 0);
    end

    // ---- reset mid-stream at count 2 ----
    cyc(1, DW'(8'h41), 4'b1010, 0, 0, 1);
    cyc(1, DW'(8'h42), 4'b1010, 0, 0, 1);
    chk("mr_cnt2", count_o, 2);
    valid_i = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("mr_valid", valid_o, 0);
    chk("mr_ctrl", ctrl_o, 0);
    chk("mr_count", count_o, 0);
    chk("mr_data", data_o, 0);
    sb.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mr_ready", ready_o, 1);
    cyc(1, DW'(8'h55), 4'b0001, 1, 0, 1);
    chk("mr_data55", data_o, 8'h55);
    cyc(0, '0, '0, 1, 0, 1);

    // ---- SKID=0 instance: combinational ready, one-edge replace ----
    v0_i = 1; d0_i = DW'(8'h61); c0_i = 4'b0101; r0_i = 0;
    #1 chk("s0_rdy_empty", r0_o, 1);
    @(posedge clk); #1;
    v0_i = 0;
    #1;
    chk("s0_rdy_full", r0_o, 0);
    chk("s0_cnt", n0_o, 1);
    chk("s0_data61", d0_o, 8'h61);
    r0_i = 1; v0_i = 1; d0_i = DW'(8'h62); c0_i = 4'b0011;
    #1 chk("s0_rdy_comb", r0_o, 1);
    @(posedge clk); #1;
    chk("s0_data62", d0_o, 8'h62);
    chk("s0_ctrl62", c0_o, 4'b0011);
    chk("s0_cnt_keep", n0_o, 1);
    r0_i = 0; v0_i = 1; f0_i = 1; d0_i = DW'(8'h63);
    @(posedge clk); #1;
    chk("s0_fl_valid", v0_o, 0);
    chk("s0_fl_ctrl", c0_o, 0);
    chk("s0_fl_cnt", n0_o, 0);
    v0_i = 0; f0_i = 0;
    @(posedge clk); #1;
    chk("s0_idle", v0_o, 0);

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised, elastic pipeline-stage register for the CPU datapath; next generation of the fixed inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a data payload and a control bundle between two stages with valid/ready handshake, stall (backpressure), flush (bubble insertion) and an optional 2-entry skid buffer.
- Control bits leaving the stage are forced to zero whenever the stage holds a bubble, so downstream RegWrite/MemWrite can never fire on an invalid slot.

Parameters:
- DATA_W, 102, payload width (pc 32 + zero 1 + ALU result 32 + RD data 32 + RD addr 5).
- CTRL_W, 4, control bundle width (RegWrite, MemToReg, MemRead, MemWrite).
- SKID, 1, 1 = two-entry skid buffer with registered ready_o; 0 = single register with combinational ready_o.

Ports:
- clk_i  input  1  clock, all state updates on rising edge.
- rst_n_i  input  1  asynchronous, active-low reset.
- valid_i  input  1  upstream stage presents a valid instruction.
- ready_o  output  1  stage can accept this cycle.
- data_i  input  DATA_W  upstream payload.
- ctrl_i  input  CTRL_W  upstream control bundle.
- flush_i  input  1  synchronous flush; kill all held entries.
- valid_o  output  1  stage output holds a valid instruction.
- ready_i  input  1  downstream accepts this cycle.
- data_o  output  DATA_W  payload of the head entry.
- ctrl_o  output  CTRL_W  control of the head entry; all-zero when valid_o=0.
- count_o  output  2  occupancy, 0..2 (0..1 when SKID=0).

Behaviour:
- Reset (rst_n_i=0, asynchronous): all valid flags 0, all data/ctrl registers 0. Outputs: valid_o=0, data_o=0, ctrl_o=0, count_o=0. ready_o is 1 from the first edge after release.
- Handshake: input transfer = valid_i & ready_o; output transfer = valid_o & ready_i. data_i/ctrl_i are sampled only on an input transfer. Entries leave in arrival order; nothing is duplicated or dropped except by flush.
- Storage: head register M (feeds data_o/ctrl_o); skid register S (SKID=1 only).
- SKID=0: ready_o = ~M.valid | ready_i (combinational). On the edge: an input transfer loads M; an output transfer with no input transfer clears M.valid; otherwise M holds. Latency 1 cycle; full throughput.
- SKID=1: ready_o = ~S.valid, driven from a register with no combinational path from ready_i. On the edge:
  - If M is empty or an output transfer occurs, M loads from S when S.valid, else from the input transfer when present, else M.valid becomes 0.
  - If an input transfer occurs while M stays occupied, or while M is refilled from S, the input loads S.
  - S.valid clears when S moves to M.
  - Latency 1 cycle when empty; sustains 1 transfer/cycle under continuous ready_i.
- Stall: ready_i=0 holds data_o/ctrl_o/valid_o stable until an output transfer.
- Flush (priority over every other event): the next edge clears M.valid and S.valid. An input transfer in the flush cycle is discarded. valid_o=0, ctrl_o=0 and count_o=0 in the following cycle. data_o retains its last value (don't-care).
- ctrl_o = M.valid ? M.ctrl : 0. data_o = M.data whether or not valid.
- count_o = M.valid + S.valid.
- Simultaneous input and output transfer at count 1 (SKID=1): M takes the new entry and count stays 1.
- At count 2, ready_o=0, so no input transfer can occur. An output transfer moves S to M, and ready_o returns to 1 next cycle.

Test Plan:
- Reset mid-stream: fill to count 2, assert rst_n_i=0 between edges -> valid_o, ctrl_o, count_o go 0 immediately; data_o=0; ready_o=1 after release.
- Streaming: ready_i=1, 8 back-to-back inputs with data_i=0x10..0x17, ctrl_i=4'b1011 -> data_o shows 0x10..0x17 on consecutive cycles, 1-cycle latency, no gaps.
- Backpressure (SKID=1): ready_i=0 while sending A=0x21, B=0x22, C=0x23 -> count_o=2 and ready_o=0 after B; C not accepted. Raise ready_i -> outputs A, B, then C, in order.
- Flush: count_o=2 with valid_i=1 and flush_i=1 for one cycle -> next cycle valid_o=0, ctrl_o=4'b0000, count_o=0. The input in the flush cycle never appears at the output.
- Bubble control: valid_i=0 with ctrl_i=4'b1111 for 3 cycles -> ctrl_o=4'b0000 and valid_o=0 throughout.
- SKID=0 build: ready_i=0 with M full -> ready_o=0 in the same cycle. Raise ready_i and valid_i together -> M replaced in one edge, count_o remains 1.
